// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl - pipeline hazard controller for the 5-stage RISC-V core.
//
// Purpose:
//   Turns NREQ prioritised stall requests into a STAGES-bit freeze vector.
//   Sequences mispredict flushes that must wait for the gate stage to move.
//   Keeps saturating stall/flush statistics.
//   Runs a watchdog that flags a pipeline stalled for TIMEOUT cycles.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   rdy           in   global ready; 0 freezes every stage
//   stall_req     in   [NREQ]   level stall requests, index 0 highest priority
//   flush_req     in   mispredict flush request pulse from EX
//   clr_stat      in   clears statistic counters and the deadlock flag
//   stall         out  [STAGES] stall vector (bit 0 = PC/IF, rising toward WB)
//   flush         out  [STAGES] bubble-insert vector, one-cycle pulses
//   flush_pending out  a flush is waiting for the gate stage
//   stall_cnt     out  [CNT_W]  cycles stalled while rdy=1 (saturating)
//   flush_cnt     out  [CNT_W]  flushes issued (saturating)
//   deadlock      out  sticky watchdog flag
module pipe_stall_ctrl #(
  parameter int                     STAGES     = 6,
  parameter int                     NREQ       = 4,
  parameter logic [NREQ*STAGES-1:0] STALL_PAT  = {6'b000010, 6'b000011, 6'b000111, 6'b011111},
  parameter logic [STAGES-1:0]      FLUSH_PAT  = 6'b000110,
  parameter int                     FLUSH_GATE = 2,
  parameter int                     CNT_W      = 32,
  parameter int                     TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              flush_req,
  input  logic              clr_stat,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              flush_pending,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              deadlock
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  if (FLUSH_GATE >= STAGES) begin : g_bad_flush_gate
    $error("pipe_stall_ctrl: FLUSH_GATE must be below STAGES");
  end

  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              deadlock_q, deadlock_d;

  logic stalled;
  logic want;
  logic gated;
  logic issue;

  // Stall resolution. Slice i of STALL_PAT sits at bits [i*STAGES +: STAGES],
  // so the default pattern gives mem (index 0) the widest freeze, 6'b011111.
  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    stall = '0;
    if (!rst) begin
      if (!rdy) begin
        stall = '1;
      end else begin
        // Descending scan: the last hit, i.e. the lowest index, wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
          if (stall_req[i]) stall = STALL_PAT[i*STAGES +: STAGES];
        end
      end
    end
  end

  always_comb begin
    stalled = rdy & (|stall);
    want    = flush_req | pending_q;
    gated   = stall[FLUSH_GATE] | ~rdy;
    issue   = want & ~gated & ~rst;
    flush   = issue ? FLUSH_PAT : '0;

    // A request arriving while one is already pending, or in the same cycle
    // the pending one issues, folds into that single flush.
    pending_d = want & gated;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    deadlock_d  = deadlock_q;
    if (clr_stat) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      deadlock_d  = 1'b0;
    end else begin
      if (stalled && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if ((|flush) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
      if (stalled && (wd_q == WD_W'(TIMEOUT - 1))) deadlock_d = 1'b1;
    end

    // Run counter: frozen while rdy=0, restarts once the pipe moves, and
    // parks at TIMEOUT so it can never wrap back under the trip point.
    wd_d = wd_q;
    if (rdy) begin
      if (!(|stall))                     wd_d = '0;
      else if (wd_q != WD_W'(TIMEOUT))   wd_d = wd_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wd_q        <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wd_q        <= wd_d;
      deadlock_q  <= deadlock_d;
    end
  end

  assign flush_pending = pending_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign deadlock      = deadlock_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with TIMEOUT=8 and CNT_W=4.
// Inputs change 1 ns after each rising edge; combinational outputs are
// checked 1 ns after that, registered outputs just after the edge.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [3:0] stall_req;
  logic       flush_req;
  logic       clr_stat;
  logic [5:0] stall;
  logic [5:0] flush;
  logic       flush_pending;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
  logic       deadlock;

  int total = 0;
  int bad   = 0;

  pipe_stall_ctrl #(
    .CNT_W   (4),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .clr_stat      (clr_stat),
    .stall         (stall),
    .flush         (flush),
    .flush_pending (flush_pending),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .deadlock      (deadlock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; stall_req = '0; flush_req = 1'b0; clr_stat = 1'b0;
    step(); step();
    #1;
    check("rst_stall_override", stall, 6'b000000);
    check("rst_flush_override", flush, 6'b000000);
    rst = 1'b0; rdy = 1'b1;
    #1;
    check("reset_pending", flush_pending, 1'b0);
    check("reset_stall_cnt", stall_cnt, 4'd0);
    check("reset_flush_cnt", flush_cnt, 4'd0);
    check("reset_deadlock", deadlock, 1'b0);

    // Priority resolution.
    step(); stall_req = 4'b0110; #1; check("prio_id_if", stall, 6'b000111);
    step(); stall_req = 4'b1111; #1; check("prio_all", stall, 6'b011111);
    step(); stall_req = 4'b1000; #1; check("prio_jump", stall, 6'b000010);
    step(); stall_req = 4'b0000; #1; check("prio_none", stall, 6'b000000);
    check("prio_stall_cnt", stall_cnt, 4'd3);

    // Global freeze with a flush arriving while frozen.
    step(); rdy = 1'b0; flush_req = 1'b1; #1;
    check("freeze_stall", stall, 6'b111111);
    check("freeze_flush_held", flush, 6'b000000);
    step(); flush_req = 1'b0; #1;
    check("freeze_pending", flush_pending, 1'b1);
    check("freeze_stall_cnt", stall_cnt, 4'd3);
    step(); rdy = 1'b1; #1;
    check("freeze_still_pending", flush_pending, 1'b1);
    check("freeze_flush_issue", flush, 6'b000110);
    step(); #1;
    check("freeze_pending_clear", flush_pending, 1'b0);
    check("freeze_flush_once", flush, 6'b000000);
    check("freeze_flush_cnt", flush_cnt, 4'd1);

    // Deferred flush behind a 3-cycle mem stall, two merged requests.
    rst = 1'b1; step(); rst = 1'b0;
    stall_req = 4'b0001; flush_req = 1'b1; #1;
    check("defer_c1_stall", stall, 6'b011111);
    check("defer_c1_flush", flush, 6'b000000);
    step(); flush_req = 1'b1; #1;
    check("defer_c2_pending", flush_pending, 1'b1);
    check("defer_c2_flush", flush, 6'b000000);
    step(); flush_req = 1'b0; #1;
    check("defer_c3_pending", flush_pending, 1'b1);
    check("defer_c3_flush", flush, 6'b000000);
    step(); stall_req = 4'b0000; #1;
    check("defer_c4_flush", flush, 6'b000110);
    step(); #1;
    check("defer_c5_flush", flush, 6'b000000);
    check("defer_c5_pending", flush_pending, 1'b0);
    step(); #1;
    check("defer_flush_cnt", flush_cnt, 4'd1);
    check("defer_stall_cnt", stall_cnt, 4'd3);

    // Unblocked flush issues in the same cycle.
    stall_req = 4'b1000; flush_req = 1'b1; #1;
    check("unblk_flush", flush, 6'b000110);
    check("unblk_stall", stall, 6'b000010);
    step(); flush_req = 1'b0; stall_req = 4'b0000; #1;
    check("unblk_pending", flush_pending, 1'b0);
    check("unblk_flush_cnt", flush_cnt, 4'd2);
    step();

    // Watchdog: trips on the 8th stalled edge and is sticky.
    stall_req = 4'b0001;
    for (int i = 0; i < 7; i++) step();
    #1; check("wd_before_trip", deadlock, 1'b0);
    step(); #1; check("wd_trip", deadlock, 1'b1);
    stall_req = 4'b0000;
    step(); #1; check("wd_sticky", deadlock, 1'b1);
    check("wd_stall_cnt", stall_cnt, 4'd12);
    clr_stat = 1'b1;
    step(); clr_stat = 1'b0; #1;
    check("clr_deadlock", deadlock, 1'b0);
    check("clr_stall_cnt", stall_cnt, 4'd0);
    check("clr_flush_cnt", flush_cnt, 4'd0);

    // Saturation at 15 for CNT_W=4.
    stall_req = 4'b0001;
    for (int i = 0; i < 20; i++) step();
    #1; check("sat_stall_cnt", stall_cnt, 4'd15);
    check("sat_deadlock", deadlock, 1'b1);

    // Reset with a flush pending and counters nonzero.
    flush_req = 1'b1;
    step(); flush_req = 1'b0; #1;
    check("rst_pre_pending", flush_pending, 1'b1);
    rst = 1'b1; #1;
    check("rst_mid_stall", stall, 6'b000000);
    check("rst_mid_flush", flush, 6'b000000);
    step(); #1;
    check("rst_pending_clear", flush_pending, 1'b0);
    check("rst_stall_cnt", stall_cnt, 4'd0);
    check("rst_deadlock", deadlock, 1'b0);
    rst = 1'b0; stall_req = 4'b0000; #1;
    check("post_rst_flush", flush, 6'b000000);
    step(); #1;
    check("post_rst_flush2", flush, 6'b000000);
    check("post_rst_flush_cnt", flush_cnt, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
